// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one sdram_controller user port between two Wishbone-style masters.
// One transaction in flight; round-robin or fixed-priority grant; reads bounded by a timeout.
module sdram_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 32,
    parameter int PRIO_MODE  = 0,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic              ctrl_rw,
    output logic [DATA_W-1:0] ctrl_wdata,
    output logic              ctrl_in_valid,
    input  logic              ctrl_busy,
    input  logic              ctrl_out_valid,
    input  logic [DATA_W-1:0] ctrl_rdata,
    output logic              grant_id,
    output logic              timeout_err
);

    localparam int CNT_W = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LIMIT = CNT_W'(RD_TIMEOUT);
    localparam logic [31:0]       TIMEOUT_WORD  = 32'hDEADBEEF;
    localparam logic [DATA_W-1:0] TIMEOUT_DATA  = DATA_W'(TIMEOUT_WORD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Both requesting: m0 always wins in fixed mode, otherwise the one not served last.
    function automatic logic pick_grant(input logic req0, input logic req1, input logic last);
        logic pick;
        if (req0 && req1) begin
            pick = (PRIO_MODE == 1) ? 1'b0 : ~last;
        end else if (req1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic              last_grant_r;
    logic              grant_id_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] m0_rdata_r;
    logic [DATA_W-1:0] m1_rdata_r;
    logic              m0_ack_r;
    logic              m1_ack_r;
    logic              in_valid_r;
    logic              timeout_err_r;

    logic              any_req_s;
    logic              pick_s;
    logic              timeout_hit_s;
    logic              capture_s;
    logic              expire_s;
    logic              in_valid_nxt_s;
    logic              m0_ack_nxt_s;
    logic              m1_ack_nxt_s;
    logic [DATA_W-1:0] rdata_nxt_s;

    assign any_req_s     = m0_req | m1_req;
    assign pick_s        = pick_grant(m0_req, m1_req, last_grant_r);
    assign timeout_hit_s = (cnt_r == TIMEOUT_LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                if (ctrl_busy) begin
                    next_state_s = ISSUE;
                end else if (we_r) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (ctrl_out_valid || timeout_hit_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RD_WAIT;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output decode: next values for the registered strobes and the read-data source.
    always_comb begin
        in_valid_nxt_s = 1'b0;
        m0_ack_nxt_s   = 1'b0;
        m1_ack_nxt_s   = 1'b0;
        capture_s      = 1'b0;
        expire_s       = 1'b0;
        rdata_nxt_s    = TIMEOUT_DATA;
        in_valid_nxt_s = (next_state_s == ISSUE);
        if (next_state_s == DONE) begin
            m0_ack_nxt_s = ~grant_id_r;
            m1_ack_nxt_s = grant_id_r;
        end else begin
            m0_ack_nxt_s = 1'b0;
            m1_ack_nxt_s = 1'b0;
        end
        if (state_r == RD_WAIT) begin
            // Data arriving on the timeout cycle still counts as a normal completion.
            capture_s = ctrl_out_valid;
            expire_s  = ~ctrl_out_valid & timeout_hit_s;
        end else begin
            capture_s = 1'b0;
            expire_s  = 1'b0;
        end
        if (capture_s) begin
            rdata_nxt_s = ctrl_rdata;
        end else begin
            rdata_nxt_s = TIMEOUT_DATA;
        end
    end

    // Command latch, timeout counter, read-data capture and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r  <= 1'b1;
            grant_id_r    <= 1'b0;
            we_r          <= 1'b0;
            addr_r        <= {ADDR_W{1'b0}};
            wdata_r       <= {DATA_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            m0_rdata_r    <= {DATA_W{1'b0}};
            m1_rdata_r    <= {DATA_W{1'b0}};
            m0_ack_r      <= 1'b0;
            m1_ack_r      <= 1'b0;
            in_valid_r    <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            in_valid_r <= in_valid_nxt_s;
            m0_ack_r   <= m0_ack_nxt_s;
            m1_ack_r   <= m1_ack_nxt_s;
            if (state_r == IDLE && any_req_s) begin
                grant_id_r   <= pick_s;
                last_grant_r <= pick_s;
                we_r         <= pick_s ? m1_we    : m0_we;
                addr_r       <= pick_s ? m1_addr  : m0_addr;
                wdata_r      <= pick_s ? m1_wdata : m0_wdata;
            end
            if (state_r == ISSUE && !ctrl_busy) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == RD_WAIT && !ctrl_out_valid && !timeout_hit_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (capture_s || expire_s) begin
                if (grant_id_r) begin
                    m1_rdata_r <= rdata_nxt_s;
                end else begin
                    m0_rdata_r <= rdata_nxt_s;
                end
            end
            if (expire_s) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

    assign m0_ack        = m0_ack_r;
    assign m1_ack        = m1_ack_r;
    assign m0_rdata      = m0_rdata_r;
    assign m1_rdata      = m1_rdata_r;
    assign ctrl_addr     = addr_r;
    assign ctrl_rw       = we_r;
    assign ctrl_wdata    = wdata_r;
    assign ctrl_in_valid = in_valid_r;
    assign grant_id      = grant_id_r;
    assign timeout_err   = timeout_err_r;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: round-robin instance (RD_TIMEOUT 15) plus a fixed-priority instance.
module tb_sdram_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [24:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        ctrl_busy, ctrl_out_valid;
    logic [31:0] ctrl_rdata;

    logic        m0_ack, m1_ack, ctrl_rw, ctrl_in_valid, grant_id, timeout_err;
    logic [31:0] m0_rdata, m1_rdata, ctrl_wdata;
    logic [24:0] ctrl_addr;

    logic        p_m0_req, p_m1_req;
    logic        p_m0_ack, p_m1_ack, p_ctrl_rw, p_ctrl_in_valid, p_grant_id, p_timeout_err;
    logic [31:0] p_m0_rdata, p_m1_rdata, p_ctrl_wdata;
    logic [24:0] p_ctrl_addr;

    int errors = 0;
    int checks = 0;

    sdram_arbiter #(.ADDR_W(25), .DATA_W(32), .PRIO_MODE(0), .RD_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_wdata(ctrl_wdata),
        .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy),
        .ctrl_out_valid(ctrl_out_valid), .ctrl_rdata(ctrl_rdata),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    sdram_arbiter #(.ADDR_W(25), .DATA_W(32), .PRIO_MODE(1), .RD_TIMEOUT(255)) dut_prio (
        .clk(clk), .rst(rst),
        .m0_req(p_m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(p_m0_ack), .m0_rdata(p_m0_rdata),
        .m1_req(p_m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(p_m1_ack), .m1_rdata(p_m1_rdata),
        .ctrl_addr(p_ctrl_addr), .ctrl_rw(p_ctrl_rw), .ctrl_wdata(p_ctrl_wdata),
        .ctrl_in_valid(p_ctrl_in_valid), .ctrl_busy(ctrl_busy),
        .ctrl_out_valid(ctrl_out_valid), .ctrl_rdata(ctrl_rdata),
        .grant_id(p_grant_id), .timeout_err(p_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 25'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 25'h0; m1_wdata = 32'h0;
        p_m0_req = 1'b0; p_m1_req = 1'b0;
        ctrl_busy = 1'b0; ctrl_out_valid = 1'b0; ctrl_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (ctrl_in_valid !== 1'b0) begin errors++; $display("FAIL reset_in_valid: got %b want 0", ctrl_in_valid); end
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {m0_ack, m1_ack}); end
        checks++; if (ctrl_rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b want 0", ctrl_rw); end
        checks++; if (ctrl_addr !== 25'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", ctrl_addr); end
        checks++; if (ctrl_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", ctrl_wdata); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant_id); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
        checks++; if ({p_ctrl_in_valid, p_grant_id, p_m0_ack, p_m1_ack} !== 4'b0000) begin errors++; $display("FAIL reset_prio_outs: got %b want 0000", {p_ctrl_in_valid, p_grant_id, p_m0_ack, p_m1_ack}); end
        @(negedge clk);
        checks++; if (ctrl_in_valid !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b want 0", ctrl_in_valid); end
    endtask

    task automatic test_single_write;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 25'h40; m0_wdata = 32'h12345678;
        @(negedge clk);
        checks++; if (ctrl_in_valid !== 1'b1) begin errors++; $display("FAIL wr_in_valid_c1: got %b want 1", ctrl_in_valid); end
        checks++; if (ctrl_rw !== 1'b1) begin errors++; $display("FAIL wr_rw: got %b want 1", ctrl_rw); end
        checks++; if (ctrl_addr !== 25'h40) begin errors++; $display("FAIL wr_addr: got %h want 40", ctrl_addr); end
        checks++; if (ctrl_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_wdata: got %h want 12345678", ctrl_wdata); end
        checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_c1: got %b want 0", m0_ack); end
        @(negedge clk);
        checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL wr_ack_c2: got %b want 1", m0_ack); end
        checks++; if (ctrl_in_valid !== 1'b0) begin errors++; $display("FAIL wr_in_valid_c2: got %b want 0", ctrl_in_valid); end
        checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL wr_m1_ack: got %b want 0", m1_ack); end
        m0_req = 1'b0;
        @(negedge clk);
        checks++; if ({m0_ack, ctrl_in_valid} !== 2'b00) begin errors++; $display("FAIL wr_after: got %b want 00", {m0_ack, ctrl_in_valid}); end
    endtask

    task automatic test_single_read;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 25'h80; m1_wdata = 32'h0;
        @(negedge clk);
        checks++; if ({ctrl_in_valid, ctrl_rw} !== 2'b10) begin errors++; $display("FAIL rd_issue: got %b want 10", {ctrl_in_valid, ctrl_rw}); end
        checks++; if (ctrl_addr !== 25'h80) begin errors++; $display("FAIL rd_addr: got %h want 80", ctrl_addr); end
        checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL rd_grant_issue: got %b want 1", grant_id); end
        @(negedge clk);
        checks++; if (ctrl_in_valid !== 1'b0) begin errors++; $display("FAIL rd_in_valid_drop: got %b want 0", ctrl_in_valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL rd_early_ack: got %b want 0 at wait %0d", m1_ack, k); end
        end
        ctrl_out_valid = 1'b1; ctrl_rdata = 32'hCAFEF00D;
        @(negedge clk);
        ctrl_out_valid = 1'b0; ctrl_rdata = 32'h0;
        checks++; if ({m1_ack, m0_ack} !== 2'b10) begin errors++; $display("FAIL rd_ack: got %b want 10", {m1_ack, m0_ack}); end
        checks++; if (m1_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_data: got %h want cafef00d", m1_rdata); end
        checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL rd_grant_done: got %b want 1", grant_id); end
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL rd_m0_untouched: got %h want 0", m0_rdata); end
        m1_req = 1'b0;
        @(negedge clk);
        checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_single: got %b want 0", m1_ack); end
    endtask

    // Both masters issue four writes each; prio selects which instance is driven and observed.
    task automatic run_contention(input bit prio, output int order_q[$], output logic [24:0] addr_q[$], output int overlap);
        int i0, i1;
        logic a0, a1, iv;
        logic [24:0] ca;
        i0 = 0; i1 = 0; overlap = 0;
        order_q.delete(); addr_q.delete();
        m0_we = 1'b1; m0_addr = 25'h100; m0_wdata = 32'hA0;
        m1_we = 1'b1; m1_addr = 25'h200; m1_wdata = 32'hB0;
        if (prio) begin p_m0_req = 1'b1; p_m1_req = 1'b1; end
        else begin m0_req = 1'b1; m1_req = 1'b1; end
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            a0 = prio ? p_m0_ack : m0_ack;
            a1 = prio ? p_m1_ack : m1_ack;
            iv = prio ? p_ctrl_in_valid : ctrl_in_valid;
            ca = prio ? p_ctrl_addr : ctrl_addr;
            if (iv) addr_q.push_back(ca);
            if (a0 && a1) overlap++;
            if (a0) begin
                order_q.push_back(0); i0++;
                if (i0 < 4) begin m0_addr = 25'h100 + 25'(i0); m0_wdata = 32'hA0 + 32'(i0); end
                else begin m0_req = 1'b0; p_m0_req = 1'b0; end
            end
            if (a1) begin
                order_q.push_back(1); i1++;
                if (i1 < 4) begin m1_addr = 25'h200 + 25'(i1); m1_wdata = 32'hB0 + 32'(i1); end
                else begin m1_req = 1'b0; p_m1_req = 1'b0; end
            end
            if (i0 >= 4 && i1 >= 4) break;
        end
        m0_req = 1'b0; m1_req = 1'b0; p_m0_req = 1'b0; p_m1_req = 1'b0;
    endtask

    task automatic test_round_robin;
        int order_q[$];
        logic [24:0] addr_q[$];
        int overlap, got_id;
        logic [24:0] exp_addr, got_addr;
        do_reset();
        run_contention(1'b0, order_q, addr_q, overlap);
        checks++; if (overlap !== 0) begin errors++; $display("FAIL rr_overlap: got %0d want 0", overlap); end
        checks++; if (order_q.size() !== 8) begin errors++; $display("FAIL rr_count: got %0d want 8", order_q.size()); end
        for (int k = 0; k < 8; k++) begin
            got_id = (k < order_q.size()) ? order_q[k] : -1;
            got_addr = (k < addr_q.size()) ? addr_q[k] : 25'h1FFFFFF;
            exp_addr = ((k % 2) == 1 ? 25'h200 : 25'h100) + 25'(k / 2);
            checks++; if (got_id !== (k % 2)) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, got_id, k % 2); end
            checks++; if (got_addr !== exp_addr) begin errors++; $display("FAIL rr_addr[%0d]: got %h want %h", k, got_addr, exp_addr); end
        end
    endtask

    task automatic test_fixed_priority;
        int order_q[$];
        logic [24:0] addr_q[$];
        int overlap, got_id, exp_id;
        logic [24:0] exp_addr, got_addr;
        do_reset();
        run_contention(1'b1, order_q, addr_q, overlap);
        checks++; if (overlap !== 0) begin errors++; $display("FAIL prio_overlap: got %0d want 0", overlap); end
        checks++; if (order_q.size() !== 8) begin errors++; $display("FAIL prio_count: got %0d want 8", order_q.size()); end
        for (int k = 0; k < 8; k++) begin
            exp_id = (k < 4) ? 0 : 1;
            got_id = (k < order_q.size()) ? order_q[k] : -1;
            got_addr = (k < addr_q.size()) ? addr_q[k] : 25'h1FFFFFF;
            exp_addr = (k < 4) ? 25'h100 + 25'(k) : 25'h200 + 25'(k - 4);
            checks++; if (got_id !== exp_id) begin errors++; $display("FAIL prio_order[%0d]: got %0d want %0d", k, got_id, exp_id); end
            checks++; if (got_addr !== exp_addr) begin errors++; $display("FAIL prio_addr[%0d]: got %h want %h", k, got_addr, exp_addr); end
        end
    endtask

    task automatic test_busy_backpressure;
        int iv_cnt, ack_cnt, unstable, stray;
        iv_cnt = 0; ack_cnt = 0; unstable = 0; stray = 0;
        ctrl_busy = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 25'h55; m0_wdata = 32'h5555AAAA;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ctrl_in_valid) begin
                iv_cnt++;
                if (ctrl_addr !== 25'h55 || ctrl_wdata !== 32'h5555AAAA || ctrl_rw !== 1'b1) unstable++;
                if (iv_cnt == 8) ctrl_busy = 1'b0;
            end
            if (m0_ack) begin ack_cnt++; m0_req = 1'b0; end
            if (m1_ack) stray++;
        end
        ctrl_busy = 1'b0;
        checks++; if (iv_cnt !== 8) begin errors++; $display("FAIL busy_in_valid_cycles: got %0d want 8", iv_cnt); end
        checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL busy_ack_count: got %0d want 1", ack_cnt); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL busy_fields_stable: got %0d changes want 0", unstable); end
        checks++; if (stray !== 0) begin errors++; $display("FAIL busy_m1_ack: got %0d want 0", stray); end
    endtask

    task automatic test_read_timeout;
        int ack_idx, late_acks;
        logic [31:0] cap;
        ack_idx = -1; late_acks = 0; cap = 32'h0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 25'h33;
        for (int idx = 1; idx <= 40; idx++) begin
            @(negedge clk);
            if (idx == 17) begin
                checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b want 0", timeout_err); end
            end
            if (m0_ack) begin ack_idx = idx; cap = m0_rdata; m0_req = 1'b0; break; end
        end
        checks++; if (ack_idx !== 18) begin errors++; $display("FAIL to_ack_cycle: got %0d want 18", ack_idx); end
        checks++; if (cap !== 32'hDEADBEEF) begin errors++; $display("FAIL to_rdata: got %h want deadbeef", cap); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
        @(negedge clk);
        ctrl_out_valid = 1'b1; ctrl_rdata = 32'h11111111;
        @(negedge clk);
        ctrl_out_valid = 1'b0; ctrl_rdata = 32'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack || ctrl_in_valid) late_acks++;
        end
        checks++; if (late_acks !== 0) begin errors++; $display("FAIL idle_out_valid_activity: got %0d want 0", late_acks); end
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_out_valid_rdata: got %h want deadbeef", m0_rdata); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_in_rd_wait;
        int acks, ack_idx;
        acks = 0; ack_idx = -1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 25'h77;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; m1_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({ctrl_in_valid, m0_ack, m1_ack} !== 3'b000) begin errors++; $display("FAIL rst_mid_outs: got %b want 000", {ctrl_in_valid, m0_ack, m1_ack}); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b want 0", timeout_err); end
        checks++; if ({grant_id, ctrl_addr} !== 26'h0) begin errors++; $display("FAIL rst_mid_cmd: got %h want 0", {grant_id, ctrl_addr}); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack || ctrl_in_valid) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rst_mid_no_ack: got %0d want 0", acks); end
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 25'h78;
        for (int idx = 1; idx <= 12; idx++) begin
            @(negedge clk);
            if (m1_ack) begin ack_idx = idx; m1_req = 1'b0; break; end
            if (idx == 3) begin ctrl_out_valid = 1'b1; ctrl_rdata = 32'h0BADF00D; end
            else begin ctrl_out_valid = 1'b0; ctrl_rdata = 32'h0; end
        end
        ctrl_out_valid = 1'b0;
        checks++; if (ack_idx !== 4) begin errors++; $display("FAIL rst_after_ack_cycle: got %0d want 4", ack_idx); end
        checks++; if (m1_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rst_after_rdata: got %h want 0badf00d", m1_rdata); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_after_err: got %b want 0", timeout_err); end
        @(negedge clk);
    endtask

    task automatic test_valid_on_timeout_cycle;
        int ack_idx;
        ack_idx = -1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 25'h99;
        for (int idx = 1; idx <= 40; idx++) begin
            @(negedge clk);
            if (m0_ack) begin ack_idx = idx; m0_req = 1'b0; break; end
            if (idx == 17) begin ctrl_out_valid = 1'b1; ctrl_rdata = 32'h600DDA7A; end
            else begin ctrl_out_valid = 1'b0; ctrl_rdata = 32'h0; end
        end
        ctrl_out_valid = 1'b0;
        checks++; if (ack_idx !== 18) begin errors++; $display("FAIL tie_ack_cycle: got %0d want 18", ack_idx); end
        checks++; if (m0_rdata !== 32'h600DDA7A) begin errors++; $display("FAIL tie_rdata: got %h want 600dda7a", m0_rdata); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tie_err: got %b want 0", timeout_err); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_busy_backpressure();
        test_read_timeout();
        test_reset_in_rd_wait();
        test_valid_on_timeout_cycle();
        test_round_robin();
        test_fixed_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-requester arbiter that shares a single sdram_controller user port.
- Sits between two Wishbone-style masters and the controller: m0 is the CPU data path, m1 is a DMA/prefetch engine.
- Serialises transactions, one outstanding at a time.
- Supports round-robin or fixed-priority grant and guards reads with a timeout.

Parameters:
- ADDR_W, 25, controller user address width.
- DATA_W, 32, data width.
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, m0 wins.
- RD_TIMEOUT, 255, maximum cycles spent in RD_WAIT before a forced completion.

Ports:
- Clock and reset (already decided): clock clk; reset rst, synchronous, active-high.
- clk  in  1  clock.
- rst  in  1  reset.
- m0_req  in  1  request; held stable, with all m0 fields, until m0_ack.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  address.
- m0_wdata  in  DATA_W  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_W  read data, valid while m0_ack is high.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0, for requester 1.
- ctrl_addr  out  ADDR_W  to controller user_addr.
- ctrl_rw  out  1  to controller rw; 1 = write.
- ctrl_wdata  out  DATA_W  to controller data_in.
- ctrl_in_valid  out  1  command valid.
- ctrl_busy  in  1  controller busy; a command is not accepted while high.
- ctrl_out_valid  in  1  read data valid.
- ctrl_rdata  in  DATA_W  controller data_out.
- grant_id  out  1  requester owning the current transaction.
- timeout_err  out  1  sticky flag: a read timed out.

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset values: state = IDLE; all acks, ctrl_in_valid and ctrl_rw = 0; addr/data outputs = 0; grant_id = 0; last_grant = 1; timeout_err = 0; timeout counter = 0.
- States: IDLE, ISSUE, RD_WAIT, DONE.
- IDLE:
  - No request: remain in IDLE.
  - Only one requester active: grant it.
  - Both active, PRIO_MODE = 1: grant m0.
  - Both active, PRIO_MODE = 0: grant ~last_grant.
  - On grant: latch id, we, addr and wdata into ctrl_* and grant_id; update last_grant; go to ISSUE.
- ISSUE:
  - ctrl_in_valid = 1; command fields held constant.
  - ctrl_busy = 1: stay in ISSUE, no timeout counting.
  - ctrl_busy = 0, write: command accepted; go to DONE.
  - ctrl_busy = 0, read: command accepted; clear counter; go to RD_WAIT.
  - ctrl_in_valid drops on the cycle after acceptance, so exactly one accepted cycle per command.
- RD_WAIT:
  - ctrl_in_valid = 0; ctrl_addr and ctrl_rw held.
  - ctrl_out_valid = 1: capture ctrl_rdata into the granted mN_rdata; go to DONE.
  - Otherwise increment the counter.
  - Counter == RD_TIMEOUT: load mN_rdata = 0xDEADBEEF; set timeout_err; go to DONE.
  - ctrl_out_valid and timeout on the same cycle: out_valid wins, data is captured, no error.
- DONE:
  - The granted mN_ack = 1 for exactly this cycle; go to IDLE.
  - This state gives the requester one cycle to drop req before IDLE samples again, so no double issue.
- mN_rdata keeps its last value outside ack. Non-granted ack is always 0; both acks are never high together.
- ctrl_out_valid outside RD_WAIT is ignored.
- Latency: write with busy low is req visible at cycle 0 -> ack at cycle 2. Read is ack 1 cycle after ctrl_out_valid.
- Reset mid-transaction: abort to IDLE and no ack for the aborted request. Each requester must re-request.
- Requester changes fields while pending: undefined. Latched values are used.
- Round-robin fairness: with both requesting continuously, grants strictly alternate: 0, 1, 0, 1, and so on.

Test Plan:
- Single write: m0 write addr 0x40, data 0x12345678, busy = 0 -> ctrl_in_valid high 1 cycle with ctrl_rw = 1, ctrl_addr = 0x40; m0_ack at cycle 2.
- Single read: m1 read addr 0x80; controller returns 0xCAFEF00D with out_valid 5 cycles after acceptance -> m1_ack 1 cycle later, m1_rdata = 0xCAFEF00D, grant_id = 1.
- Round-robin: both request 4 back-to-back writes, PRIO_MODE = 0 -> grant order 0, 1, 0, 1, 0, 1, 0, 1; no ack overlap. PRIO_MODE = 1 -> all m0 first.
- Busy backpressure: busy held high 7 cycles during ISSUE -> ctrl_in_valid held 8 cycles with stable fields; exactly one ack.
- Read timeout: RD_TIMEOUT = 15, no out_valid -> ack after timeout with rdata = 0xDEADBEEF and timeout_err = 1. A later out_valid in IDLE is ignored.
- Reset in RD_WAIT: assert rst 1 cycle -> state IDLE, no ack, timeout_err = 0; a subsequent read completes normally.
